// File: rtl/stream_pkg.sv
// Shared stream helpers: beat-counter width function and the valid/ready pair type,
// reused by both the serializer and the companion deserializer.
package stream_pkg;

  typedef struct packed {
    logic valid;
    logic ready;
  } stream_hs_t;

  // Counter width for a given beat ratio; never narrower than one bit.
  function automatic int beat_cnt_bit(input int ratio);
    return (ratio <= 2) ? 1 : $clog2(ratio);
  endfunction

endpackage

// File: rtl/stream_serializer_if.sv
// Handshake bundle for stream_serializer: wide input stream plus narrow output stream.
// o_output_last is present only when STREAM_SER_LAST_EN is defined.
interface stream_serializer_if #(
  parameter int WIDTH = 8,
  parameter int RATIO = 4
);
  logic                     o_input_ready;
  logic                     i_input_valid;
  logic [WIDTH*RATIO-1:0]   i_input_data;
  logic                     i_output_ready;
  logic                     o_output_valid;
  logic [WIDTH-1:0]         o_output_data;
`ifdef STREAM_SER_LAST_EN
  logic                     o_output_last;
`endif

  modport slave (
    output o_input_ready,
    input  i_input_valid,
    input  i_input_data,
    input  i_output_ready,
    output o_output_valid,
    output o_output_data
`ifdef STREAM_SER_LAST_EN
    , output o_output_last
`endif
  );

  modport master (
    input  o_input_ready,
    output i_input_valid,
    output i_input_data,
    output i_output_ready,
    input  o_output_valid,
    input  o_output_data
`ifdef STREAM_SER_LAST_EN
    , input o_output_last
`endif
  );

endinterface

// File: rtl/stream_beat_counter.sv
// Beat index counter: clear has priority, inc wraps to zero after RATIO-1.
module stream_beat_counter #(
  parameter int RATIO   = 4,
  parameter int CNT_BIT = 2
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_inc,
  input  logic               i_clear,
  output logic [CNT_BIT-1:0] o_cnt,
  output logic               o_wrap
);

  logic [CNT_BIT-1:0] cnt_reg, cnt_next;

  assign o_cnt  = cnt_reg;
  assign o_wrap = (cnt_reg == CNT_BIT'(RATIO - 1));

  always_comb begin
    cnt_next = cnt_reg;
    if (i_clear) begin
      cnt_next = '0;
    end else if (i_inc) begin
      cnt_next = o_wrap ? '0 : cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

endmodule

// File: rtl/stream_serializer.sv
// Wide-to-narrow stream serializer: one WIDTH*RATIO word out as RATIO beats, LSB slice first.
// Optional o_output_last frame marker enabled by defining STREAM_SER_LAST_EN.
module stream_serializer
  import stream_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int RATIO   = 4,
  parameter int CNT_BIT = beat_cnt_bit(RATIO)
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  stream_serializer_if.slave   s
);

  logic [WIDTH*RATIO-1:0] buf_reg;
  logic                   full_reg, full_next;
  logic [CNT_BIT-1:0]     cnt;
  logic                   last_beat;
  logic                   input_ready;
  logic                   wr_en, rd_en;
  stream_hs_t             in_hs, out_hs;
  logic [WIDTH-1:0]       slice [RATIO];

  assign out_hs      = '{valid: full_reg, ready: s.i_output_ready};
  assign rd_en       = out_hs.valid & out_hs.ready;
  // Refill is allowed in the same cycle the final beat drains, so ready follows i_output_ready.
  assign input_ready = !full_reg | (rd_en & last_beat);
  assign in_hs       = '{valid: s.i_input_valid, ready: input_ready};
  assign wr_en       = in_hs.valid & in_hs.ready;

  stream_beat_counter #(
    .RATIO   (RATIO),
    .CNT_BIT (CNT_BIT)
  ) u_beat_counter (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_inc   (rd_en),
    .i_clear (wr_en | (rd_en & last_beat)),
    .o_cnt   (cnt),
    .o_wrap  (last_beat)
  );

  always_comb begin
    full_next = full_reg;
    if (wr_en) begin
      full_next = 1'b1;
    end else if (rd_en & last_beat) begin
      full_next = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      full_reg <= 1'b0;
    end else begin
      full_reg <= full_next;
    end
  end

  // Hold register is pure datapath; full_reg qualifies it.
  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      buf_reg <= s.i_input_data;
    end
  end

  for (genvar gi = 0; gi < RATIO; gi++) begin : g_slice
    assign slice[gi] = buf_reg[gi*WIDTH +: WIDTH];
  end

  assign s.o_input_ready  = input_ready;
  assign s.o_output_valid = full_reg;
  assign s.o_output_data  = slice[cnt];
`ifdef STREAM_SER_LAST_EN
  assign s.o_output_last  = full_reg & last_beat;
`endif

endmodule

// File: doc/stream_serializer.md
Name: stream_serializer

Overview:
- Consumer end of a valid/ready stream, e.g. draining a FIFO output port.
- Accepts one wide word of WIDTH*RATIO bits and emits RATIO narrow beats of WIDTH bits each, LSB slice first.
- Used between wide buffers (weight/activation FIFOs) and narrow PE-array feed ports.
- Sustains full throughput: one narrow beat per cycle, with no bubble between consecutive words.

Parameters:
- WIDTH, 8: width of one output beat in bits.
- RATIO, 4: beats per input word. Must be ≥ 2.
- CNT_BIT, $clog2(RATIO): width of the beat counter.

Ports:
- i_clk, input, 1: clock.
- i_reset, input, 1: reset, asynchronous, active-low.
- o_input_ready, output, 1: block can accept a wide word this cycle.
- i_input_valid, input, 1: upstream offers a wide word.
- i_input_data, input, WIDTH*RATIO: wide word. Slice k is bits [k*WIDTH +: WIDTH].
- i_output_ready, output-side input, 1: downstream accepts a beat.
- o_output_valid, output, 1: a beat is presented.
- o_output_data, output, WIDTH: current beat.
- o_output_last, output, 1: only when STREAM_SER_LAST_EN is defined (see Optional Feature).

Behaviour:
- State:
  - hold register `buf` (WIDTH*RATIO): not reset, datapath only.
  - beat counter `cnt` (CNT_BIT): reset to 0.
  - occupancy flag `full`: reset to 0.
- Reset (asynchronous, any time, including mid-word): full=0, cnt=0.
  - Outputs: o_output_valid=0, o_input_ready=1, o_output_last=0.
  - A partially sent word is discarded.
- Handshake terms:
  - rd_en = o_output_valid & i_output_ready.
  - wr_en = o_input_ready & i_input_valid.
- o_output_valid = full.
- o_output_data = buf[cnt*WIDTH +: WIDTH]. This is a combinational mux with no extra latency.
- last_beat = (cnt == RATIO-1).
- o_input_ready = !full | (rd_en & last_beat). Back-to-back refill is allowed on the final beat. o_input_ready therefore depends combinationally on i_output_ready; this is a documented path.
- On wr_en: buf <= i_input_data, cnt <= 0, full <= 1.
- On rd_en & !last_beat: cnt <= cnt+1.
- On rd_en & last_beat & !wr_en: full <= 0, cnt <= 0.
- Simultaneous final-beat read and write: the new word is loaded, full stays 1, cnt <= 0. The next cycle presents slice 0 of the new word.
- Latency: a word accepted at cycle t shows beat 0 at t+1.
- Stall: while i_output_ready=0, o_output_valid and o_output_data stay stable. The upstream word is not taken.
- Once asserted, o_output_valid is never deasserted before the handshake completes.
- i_input_data is sampled only on wr_en. Changes while not ready are ignored.

Optional Feature:
- Macro: STREAM_SER_LAST_EN.
- Defined:
  - Adds port o_output_last = full & last_beat, asserted on beat RATIO-1 of every word.
  - Intended for frame delimiting toward the PE array.
- Undefined:
  - Port absent.
  - All other behaviour identical.

Decomposition:
- Shared package stream_pkg:
  - function beat_cnt_bit(ratio), returning $clog2 with a minimum of 1.
  - typedef of the handshake pair struct {valid, ready}, for later reuse by the deserializer.
- Natural sub-module: stream_beat_counter, a wrap counter with inc, clear and wrap-flag output.
- Everything else stays in the top module.

Test Plan (WIDTH=8, RATIO=4):
- Reset, then idle: o_output_valid=0 and o_input_ready=1. Release reset with no input: outputs unchanged.
- Single word 0xDDCCBBAA, i_output_ready=1 always: beats 0xAA, 0xBB, 0xCC, 0xDD on 4 consecutive cycles starting one cycle after accept. o_output_last (macro on) high only with 0xDD. o_input_ready is high in the 0xDD cycle.
- Two words back-to-back (0x44332211, 0x88776655) with continuous ready: 8 beats 0x11..0x88 with no gap. The second word is accepted in the same cycle as beat 0x44.
- Downstream stall: drop i_output_ready for 3 cycles after beat 0xBB is shown. 0xBB is held stable, o_input_ready=0 with upstream valid, and there is no beat loss or duplication.
- Reset asserted mid-word, after 2 beats: asynchronous clear with valid=0 immediately. After release, new word 0x0F0E0D0C is emitted from 0x0C.
- Random valid/ready toggling over 1000 words against a scoreboard: exact beat order preserved, no valid drop without a handshake, and o_output_last count equals the word count.
